// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared branch-type encodings and branch-condition evaluation
//               for the PC / return-address-stack unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Branch type field as driven by the control FSM
    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_LT = 2'b01,
        BR_NE = 2'b10,
        BR_GE = 2'b11
    } br_type_e;

    // Evaluate a branch condition from the ALU zero/negative flags
    function automatic logic branch_cond(input br_type_e bt,
                                         input logic     zero,
                                         input logic     negative);
        logic cond;
        cond = 1'b0;
        case (bt)
            BR_EQ:   cond = zero;
            BR_LT:   cond = negative;
            BR_NE:   cond = ~zero;
            BR_GE:   cond = ~negative;
            default: cond = 1'b0;
        endcase
        return cond;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack (LIFO). A push into a full
//               stack overwrites the oldest entry; a pop from an empty stack
//               is ignored. Overflow/underflow flag the offending request in
//               the same cycle it is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4,
    localparam int C_PTR_W  = $clog2(RAS_DEPTH),
    localparam int C_CNT_W  = $clog2(RAS_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [WIDTH-1:0]   i_push_data,
    output logic [WIDTH-1:0]   o_top,
    output logic [C_CNT_W-1:0] o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_overflow,
    output logic               o_underflow
);

    logic [WIDTH-1:0]   r_mem [RAS_DEPTH];
    logic [C_PTR_W-1:0] r_ptr;      // next slot to be written
    logic [C_CNT_W-1:0] r_count;
    logic [C_PTR_W-1:0] w_top_idx;
    logic [C_PTR_W-1:0] w_ptr_inc;

    // Pointer arithmetic wraps at RAS_DEPTH, which need not be a power of two
    assign w_top_idx = (r_ptr == '0) ? C_PTR_W'(RAS_DEPTH - 1) : r_ptr - C_PTR_W'(1);
    assign w_ptr_inc = (r_ptr == C_PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ptr + C_PTR_W'(1);

    assign o_top       = r_mem[w_top_idx];
    assign o_count     = r_count;
    assign o_full      = (r_count == C_CNT_W'(RAS_DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_overflow  = i_push & o_full;
    assign o_underflow = i_pop & o_empty;

    // Stack storage, pointer and occupancy; push takes precedence over pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_ptr] <= i_push_data;
            r_ptr        <= w_ptr_inc;
            if (!o_full) begin
                r_count <= r_count + C_CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - C_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_unit
// Description : Program counter with conditional branches, sequential
//               fall-through and call/return through a return-address stack.
//               Priority on a PC write: return > call > branch > jump.
//               Optional macro PC_ALIGN_CHECK_EN: a misaligned target leaves
//               the PC unchanged and sets sticky output_misaligned.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int RAS_DEPTH   = 4,
    parameter int RESET_PC    = 0,
    parameter int INSTR_BYTES = 2,
    localparam int C_CNT_W    = $clog2(RAS_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             input_PCWrite,
    input  logic [WIDTH-1:0] input_newPC,
    input  logic             input_PC_isbranch,
    input  logic [1:0]       input_branchType,
    input  logic             input_zero,
    input  logic             input_negative,
    input  logic             input_call,
    input  logic             input_return,
    output logic [WIDTH-1:0] output_PC,
    output logic             output_branch_taken,
    output logic             output_RAS_empty,
    output logic             output_RAS_full,
`ifdef PC_ALIGN_CHECK_EN
    output logic             output_misaligned,
`endif
    output logic             output_RAS_error
);

    logic [WIDTH-1:0]   r_pc;
    logic               r_taken;
    logic               r_err;
    logic [WIDTH-1:0]   w_pc_inc;
    logic [WIDTH-1:0]   w_pc_next;
    logic               w_taken_next;
    logic               w_load_target;
    logic               w_cond;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_ras_top;
    logic [C_CNT_W-1:0] w_ras_count;
    logic               w_ras_full;
    logic               w_ras_empty;
    logic               w_ras_overflow;
    logic               w_ras_underflow;
`ifdef PC_ALIGN_CHECK_EN
    logic               r_mis;
    logic               w_target_misaligned;
    assign w_target_misaligned = ((input_newPC % WIDTH'(INSTR_BYTES)) != '0);
`endif

    // Sequential address; modulo 2^WIDTH by construction
    assign w_pc_inc = r_pc + WIDTH'(INSTR_BYTES);
    assign w_cond   = branch_cond(br_type_e'(input_branchType), input_zero, input_negative);

    // A return always requests a pop (the stack reports underflow when empty);
    // a call only pushes when no return is present this cycle
    assign w_pop  = input_PCWrite & input_return;
    assign w_push = input_PCWrite & input_call & ~input_return;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (CLK),
        .rst_n       (RST_N),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_count     (w_ras_count),
        .o_full      (w_ras_full),
        .o_empty     (w_ras_empty),
        .o_overflow  (w_ras_overflow),
        .o_underflow (w_ras_underflow)
    );

    // Next-PC selection: return > call > branch > jump
    always_comb begin
        w_pc_next     = r_pc;
        w_taken_next  = r_taken;
        w_load_target = 1'b0;
        if (input_PCWrite) begin
            w_taken_next = 1'b0;
            if (input_return) begin
                if (!w_ras_empty) begin
                    w_pc_next = w_ras_top;
                end else begin
                    w_load_target = 1'b1;
                end
            end else if (input_call) begin
                w_load_target = 1'b1;
            end else if (input_PC_isbranch) begin
                w_taken_next = w_cond;
                if (w_cond) begin
                    w_load_target = 1'b1;
                end else begin
                    w_pc_next = w_pc_inc;
                end
            end else begin
                w_load_target = 1'b1;
            end
`ifdef PC_ALIGN_CHECK_EN
            if (w_load_target && !w_target_misaligned) begin
                w_pc_next = input_newPC;
            end
`else
            if (w_load_target) begin
                w_pc_next = input_newPC;
            end
`endif
        end
    end

    // PC, branch-taken and sticky stack-error registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc    <= WIDTH'(RESET_PC);
            r_taken <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_taken <= w_taken_next;
            r_err   <= r_err | w_ras_overflow | w_ras_underflow;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky flag for a rejected misaligned target load
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mis <= 1'b0;
        end else if (w_load_target && w_target_misaligned) begin
            r_mis <= 1'b1;
        end
    end
    assign output_misaligned = r_mis;
`endif

    assign output_PC           = r_pc;
    assign output_branch_taken = r_taken;
    assign output_RAS_empty    = (w_ras_count == '0);
    assign output_RAS_full     = w_ras_full;
    assign output_RAS_error    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ras_unit
// Description : Self-checking bench for pc_ras_unit: directed scenarios then
//               randomized writes against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ras_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int IB    = 2;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             input_PCWrite;
    logic [WIDTH-1:0] input_newPC;
    logic             input_PC_isbranch;
    logic [1:0]       input_branchType;
    logic             input_zero;
    logic             input_negative;
    logic             input_call;
    logic             input_return;
    logic [WIDTH-1:0] output_PC;
    logic             output_branch_taken;
    logic             output_RAS_empty;
    logic             output_RAS_full;
    logic             output_RAS_error;
`ifdef PC_ALIGN_CHECK_EN
    logic             output_misaligned;
`endif

    pc_ras_unit #(
        .WIDTH       (WIDTH),
        .RAS_DEPTH   (DEPTH),
        .RESET_PC    (0),
        .INSTR_BYTES (IB)
    ) dut (
        .CLK                 (CLK),
        .RST_N               (RST_N),
        .input_PCWrite       (input_PCWrite),
        .input_newPC         (input_newPC),
        .input_PC_isbranch   (input_PC_isbranch),
        .input_branchType    (input_branchType),
        .input_zero          (input_zero),
        .input_negative      (input_negative),
        .input_call          (input_call),
        .input_return        (input_return),
        .output_PC           (output_PC),
        .output_branch_taken (output_branch_taken),
        .output_RAS_empty    (output_RAS_empty),
        .output_RAS_full     (output_RAS_full),
`ifdef PC_ALIGN_CHECK_EN
        .output_misaligned   (output_misaligned),
`endif
        .output_RAS_error    (output_RAS_error)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_stack[$];
    logic             m_taken;
    logic             m_err;
    logic             m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    32'(output_PC),           32'(m_pc));
        chk({tag, ".taken"}, 32'(output_branch_taken), 32'(m_taken));
        chk({tag, ".empty"}, 32'(output_RAS_empty),    32'(m_stack.size() == 0));
        chk({tag, ".full"},  32'(output_RAS_full),     32'(m_stack.size() == DEPTH));
        chk({tag, ".error"}, 32'(output_RAS_error),    32'(m_err));
`ifdef PC_ALIGN_CHECK_EN
        chk({tag, ".mis"},   32'(output_misaligned),   32'(m_mis));
`endif
    endtask

    task automatic model_reset();
        m_pc    = '0;
        m_stack.delete();
        m_taken = 1'b0;
        m_err   = 1'b0;
        m_mis   = 1'b0;
    endtask

    // One PC write, straight from the behavioural rules
    task automatic model_write(input logic ret, input logic call, input logic br,
                               input logic [1:0] bt, input logic z, input logic n,
                               input logic [WIDTH-1:0] np);
        logic             load;
        logic             cond;
        logic [WIDTH-1:0] nxt;
        load = 1'b0;
        cond = 1'b0;
        nxt  = m_pc;
        m_taken = 1'b0;
        if (ret) begin
            if (m_stack.size() > 0) nxt = m_stack.pop_back();
            else begin load = 1'b1; m_err = 1'b1; end
        end else if (call) begin
            m_stack.push_back(WIDTH'(m_pc + IB));
            if (m_stack.size() > DEPTH) begin
                m_stack.delete(0);
                m_err = 1'b1;
            end
            load = 1'b1;
        end else if (br) begin
            case (bt)
                2'd0: cond = z;
                2'd1: cond = n;
                2'd2: cond = !z;
                default: cond = !n;
            endcase
            m_taken = cond;
            if (cond) load = 1'b1;
            else nxt = WIDTH'(m_pc + IB);
        end else begin
            load = 1'b1;
        end
        if (load) begin
`ifdef PC_ALIGN_CHECK_EN
            if ((np % IB) != 0) m_mis = 1'b1;
            else nxt = np;
`else
            nxt = np;
`endif
        end
        m_pc = nxt;
    endtask

    // Drive one cycle, update the model, sample 1 time unit after the edge
    task automatic cyc(input string tag, input logic w, input logic ret, input logic call,
                       input logic br, input logic [1:0] bt, input logic z, input logic n,
                       input logic [WIDTH-1:0] np);
        input_PCWrite     = w;
        input_return      = ret;
        input_call        = call;
        input_PC_isbranch = br;
        input_branchType  = bt;
        input_zero        = z;
        input_negative    = n;
        input_newPC       = np;
        if (w) model_write(ret, call, br, bt, z, n, np);
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        RST_N = 1'b0;
        input_PCWrite = 0; input_newPC = '0; input_PC_isbranch = 0; input_branchType = 0;
        input_zero = 0; input_negative = 0; input_call = 0; input_return = 0;
        model_reset();
        #1;
        check_all("reset_async");
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset_held");
        RST_N = 1'b1;

        // Plain jump, then hold with PCWrite low
        cyc("jump",    1, 0, 0, 0, 2'b00, 0, 0, 16'h1234);
        chk("jump_lit", 32'(output_PC), 32'h1234);
        cyc("hold",    0, 0, 0, 0, 2'b00, 0, 0, 16'h1111);
        chk("hold_lit", 32'(output_PC), 32'h1234);

        // Not-taken bne, then taken blt
        cyc("j20",     1, 0, 0, 0, 2'b00, 0, 0, 16'h0020);
        cyc("bne_nt",  1, 0, 0, 1, 2'b10, 1, 0, 16'h0080);
        chk("bne_nt_lit", 32'(output_PC), 32'h0022);
        cyc("blt_t",   1, 0, 0, 1, 2'b01, 0, 1, 16'h0054);
        chk("blt_t_lit", 32'({output_PC, output_branch_taken}), {15'd0, 16'h0054, 1'b1});
        cyc("bge_nt",  1, 0, 0, 1, 2'b11, 0, 1, 16'h0300);
        cyc("beq_t",   1, 0, 0, 1, 2'b00, 1, 0, 16'h0310);
        cyc("j_clr",   1, 0, 0, 0, 2'b00, 0, 0, 16'h0100);

        // Call/return pair
        cyc("call",    1, 0, 1, 0, 2'b00, 0, 0, 16'h0400);
        chk("call_lit", 32'({output_PC, output_RAS_empty}), {15'd0, 16'h0400, 1'b0});
        cyc("ret",     1, 1, 0, 0, 2'b00, 0, 0, 16'h0999);
        chk("ret_lit", 32'({output_PC, output_RAS_empty}), {15'd0, 16'h0102, 1'b1});

        // Five nested calls overflow a four-entry stack
        for (int i = 1; i <= 5; i++) begin
            cyc("ncall", 1, 0, 1, 0, 2'b00, 0, 0, WIDTH'(i * 16'h1000));
        end
        chk("ovf_lit", 32'({output_RAS_full, output_RAS_error}), 32'b11);
        for (int i = 4; i >= 1; i--) begin
            cyc("nret", 1, 1, 0, 0, 2'b00, 0, 0, 16'h0000);
            chk("nret_lit", 32'(output_PC), 32'(WIDTH'(i * 16'h1000 + 2)));
        end
        chk("drained_lit", 32'(output_RAS_empty), 32'd1);

        // call+return together: return wins, no push
        cyc("callret", 1, 1, 1, 0, 2'b00, 0, 0, 16'h0500);

        // Underflow, then asynchronous reset mid-sequence
        cyc("ret_empty", 1, 1, 0, 0, 2'b00, 0, 0, 16'h0200);
        chk("ret_empty_lit", 32'({output_PC, output_RAS_error}), {15'd0, 16'h0200, 1'b1});
        cyc("push1",   1, 0, 1, 0, 2'b00, 0, 0, 16'h0600);
        #3 RST_N = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        #2 RST_N = 1'b1;

        // Wrap on fall-through
        cyc("jfffe",   1, 0, 0, 0, 2'b00, 0, 0, 16'hFFFE);
        cyc("wrap",    1, 0, 0, 1, 2'b00, 0, 0, 16'h4444);
        chk("wrap_lit", 32'(output_PC), 32'h0000);
        cyc("odd_jump", 1, 0, 0, 0, 2'b00, 0, 0, 16'h0013);

        // Randomized writes against the model
        for (int k = 0; k < 400; k++) begin
            logic [WIDTH-1:0] np;
            np = WIDTH'($urandom);
            if ($urandom_range(7) != 0) np[0] = 1'b0;
            cyc("rand", ($urandom_range(3) != 0), ($urandom_range(4) == 0),
                ($urandom_range(3) == 0), 1'($urandom_range(1)), 2'($urandom_range(3)),
                1'($urandom_range(1)), 1'($urandom_range(1)), np);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program-counter unit for the multi-cycle datapath; successor to the fixed 16-bit PC.
- Adds four branch conditions, sequential fall-through on not-taken branches, and call/return through a small return-address stack (RAS).
- Sits between the control FSM (PCWrite, branch, call and return strobes), the ALU flags and the instruction-memory address.

Parameters:
WIDTH, 16, PC and address width in bits
RAS_DEPTH, 4, number of return-address stack entries (>=2)
RESET_PC, 0, PC value after reset
INSTR_BYTES, 2, fall-through and return-address increment

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
input_PCWrite  input  1  PC update enable from control FSM
input_newPC  input  WIDTH  jump, branch or call target
input_PC_isbranch  input  1  conditional branch in this write
input_branchType  input  2  00 beq, 01 blt, 10 bne, 11 bge
input_zero  input  1  ALU zero flag
input_negative  input  1  ALU negative flag
input_call  input  1  push return address and jump
input_return  input  1  pop return address into PC
output_PC  output  WIDTH  current PC (registered)
output_branch_taken  output  1  registered: last write was a taken branch
output_RAS_empty  output  1  stack count == 0
output_RAS_full  output  1  stack count == RAS_DEPTH
output_RAS_error  output  1  sticky: overflow or underflow occurred

Behaviour:
Reset (asynchronous on RST_N low, any time including mid-sequence):
- output_PC = RESET_PC; stack count = 0; output_branch_taken = 0; output_RAS_error = 0.
- output_RAS_empty = 1; output_RAS_full = 0.

input_PCWrite = 0:
- All state holds. Strobes are ignored.

input_PCWrite = 1: one rising edge performs exactly one action. Priority is return > call > branch > jump.
- Return:
  - Stack not empty: PC <= top entry; count decrements.
  - Stack empty: PC <= input_newPC; output_RAS_error set.
- Call:
  - PC <= input_newPC; push (PC + INSTR_BYTES).
  - Stack full: oldest entry is overwritten (circular), count stays RAS_DEPTH, output_RAS_error set.
- Branch (isbranch = 1):
  - Condition is beq: zero; blt: negative; bne: !zero; bge: !negative.
  - Taken: PC <= input_newPC. Not taken: PC <= PC + INSTR_BYTES.
  - output_branch_taken <= condition.
- Plain jump (no strobes): PC <= input_newPC.
- output_branch_taken <= 0 for every write that is not a branch.
- call and return together: return wins and no push occurs.

Arithmetic and flags:
- All PC arithmetic is modulo 2^WIDTH; PC = 2^WIDTH - INSTR_BYTES plus INSTR_BYTES wraps to 0.
- output_RAS_error clears only on reset.
- output_RAS_empty and output_RAS_full are decoded from the registered count; both update on the edge after a push or pop.
- Latency: every registered output reflects the action one edge after input_PCWrite is sampled.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: a write that would load input_newPC with input_newPC mod INSTR_BYTES != 0 leaves PC unchanged and sets sticky output port output_misaligned (reset 0).
  - The stack side effects of that write still apply: a push still occurs, a pop still occurs, and error flags still update.
- Undefined: targets load unchanged; output_misaligned is absent.

Decomposition:
- Package pc_pkg:
  - branch-type encodings BR_EQ, BR_LT, BR_NE, BR_GE;
  - branch-condition evaluation function.
- Sub-module pc_ras: circular LIFO of RAS_DEPTH x WIDTH with push, pop, top, count, full/empty and overflow/underflow outputs.
- pc_ras_unit holds the PC register, priority logic and flag registers.

Test Plan:
- Reset, then PCWrite=1, newPC=0x1234, no strobes -> PC=0x1234, branch_taken=0; PCWrite=0 with newPC=0x1111 -> PC stays 0x1234.
- PC=0x0020; branch bne with zero=1 -> PC=0x0022, taken=0; next branch blt with negative=1, newPC=0x0054 -> PC=0x0054, taken=1.
- PC=0x0100; call with newPC=0x0400 -> PC=0x0400, empty=0; return -> PC=0x0102, empty=1.
- Five nested calls with RAS_DEPTH=4 -> full=1, error=1; four returns pop the four most recent return addresses, then empty=1.
- Return while empty with newPC=0x0200 -> PC=0x0200, error=1; assert RST_N low mid-sequence -> PC=RESET_PC, error=0, empty=1.
- PC=0xFFFE; branch beq with zero=0 -> PC=0x0000 (wrap). With PC_ALIGN_CHECK_EN defined, a jump with newPC=0x0013 -> PC unchanged, misaligned=1.
